// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI-RAM target (0x03 read / 0x02 write) with backdoor port
// SPI pins are oversampled in the clk domain; memory is 2^ADDR_WIDTH bytes, not reset.
module spi_ram_responder #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CLK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic                  busy,
  output logic                  cmd_err,
  input  logic                  bd_we,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [7:0]            bd_wdata,
  output logic [7:0]            bd_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_cs_s1, r_cs_s2, r_cs_prev;
  logic r_mosi_s1, r_mosi_s2;

  logic [22:0]           r_shift;
  logic [4:0]            r_bit_cnt;
  logic [2:0]            r_tx_cnt;
  logic [7:0]            r_tx;
  logic                  r_is_read;
  logic                  r_fetch;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_cmd_err;
  logic [7:0]            r_bd_rdata;
  logic [7:0]            r_mem [0:(2**ADDR_WIDTH)-1];

  logic        w_rise, w_fall;
  logic [23:0] w_shift_next;
  logic        w_cmd_err, w_spi_we, w_addr_load, w_set_read, w_set_write;
  logic        w_unused_bits;

  // Synchronizers keep tracking the pins through reset so a held-low CS_N
  // is seen as "already low" afterwards rather than as a fresh falling edge.
  always_ff @(posedge clk) begin
    r_clk_s1   <= CLK;
    r_clk_s2   <= r_clk_s1;
    r_clk_prev <= r_clk_s2;
    r_cs_s1    <= CS_N;
    r_cs_s2    <= r_cs_s1;
    r_cs_prev  <= r_cs_s2;
    r_mosi_s1  <= MOSI;
    r_mosi_s2  <= r_mosi_s1;
  end

  assign w_rise        = r_clk_s2 & ~r_clk_prev;
  assign w_fall        = ~r_clk_s2 & r_clk_prev;
  assign w_shift_next  = {r_shift, r_mosi_s2};
  assign w_unused_bits = ^w_shift_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_err   = 1'b0;
    w_spi_we    = 1'b0;
    w_addr_load = 1'b0;
    w_set_read  = 1'b0;
    w_set_write = 1'b0;
    if (r_cs_s2) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = r_cs_prev ? S_CMD : S_IGNORE;
        S_CMD: begin
          if (w_rise && r_bit_cnt == 5'd7) begin
            if (w_shift_next[7:0] == 8'h03) begin
              w_next     = S_ADDR;
              w_set_read = 1'b1;
            end else if (w_shift_next[7:0] == 8'h02) begin
              w_next      = S_ADDR;
              w_set_write = 1'b1;
            end else begin
              w_next    = S_IGNORE;
              w_cmd_err = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_rise && r_bit_cnt == 5'd23) begin
            w_addr_load = 1'b1;
            w_next      = r_is_read ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_rise && r_bit_cnt == 5'd7) begin
            w_spi_we = 1'b1;
          end
        end
        S_RDATA:  w_next = S_RDATA;
        S_IGNORE: w_next = S_IGNORE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx_cnt  <= '0;
      r_tx      <= '0;
      r_is_read <= 1'b0;
      r_fetch   <= 1'b0;
      r_addr    <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err;
      r_fetch   <= 1'b0;
      if (w_rise) begin
        r_shift <= w_shift_next[22:0];
      end
      if (r_state != w_next || w_spi_we) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_set_read) begin
        r_is_read <= 1'b1;
      end else if (w_set_write) begin
        r_is_read <= 1'b0;
      end
      if (w_addr_load) begin
        r_addr <= w_shift_next[ADDR_WIDTH-1:0];
      end else if (w_spi_we || r_fetch) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_addr_load && r_is_read) begin
        r_fetch <= 1'b1;
      end
      if (r_state == S_RDATA && w_fall) begin
        r_miso    <= r_tx[7];
        r_miso_oe <= 1'b1;
        r_tx      <= {r_tx[6:0], 1'b0};
        r_tx_cnt  <= r_tx_cnt + 3'd1;
        if (r_tx_cnt == 3'd7) begin
          r_fetch <= 1'b1;
        end
      end
      // The next byte is fetched straight into the shifter; a fall cannot
      // land in the same cycle because fetches trail a rise or a fall.
      if (r_fetch) begin
        r_tx <= r_mem[r_addr];
      end
      if (w_next != S_RDATA) begin
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_tx_cnt  <= '0;
      end
    end
  end

  // SPI write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
    if (w_spi_we && !reset) begin
      r_mem[r_addr] <= w_shift_next[7:0];
    end
    r_bd_rdata <= r_mem[bd_addr];
  end

  assign MISO     = r_miso;
  assign MISO_OE  = r_miso_oe;
  assign busy     = ~r_cs_s2 & ~reset;
  assign cmd_err  = r_cmd_err;
  assign bd_rdata = r_bd_rdata;

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - self-checking bench for spi_ram_responder
// Directed frame table, hand-written abort/reset sequences, random frames vs an array model.
module tb_spi_ram_responder;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, busy, cmd_err;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0;
  logic [7:0]  bd_rdata;

  spi_ram_responder #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .CLK(spi_clk), .CS_N(cs_n), .MOSI(mosi),
    .MISO(miso), .MISO_OE(miso_oe), .busy(busy), .cmd_err(cmd_err),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_total = 0;
  int oe_bad = 0;
  logic [7:0] ref_mem [0:65535];
  logic       ref_valid [0:65535];

  always @(negedge clk) if (cmd_err === 1'b1) err_total++;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    tick(1);
    bd_we = 1'b0;
    ref_mem[a] = d;
    ref_valid[a] = 1'b1;
  endtask

  task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
    bd_addr = a;
    tick(1);
    d = bd_rdata;
  endtask

  task automatic spi_bit(input logic tx, input logic oe_exp, output logic rx);
    mosi = tx;
    tick(HALF);
    rx = miso;
    if (miso_oe !== oe_exp) oe_bad++;
    spi_clk = 1'b1;
    tick(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic oe_exp, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], oe_exp, rx[i]);
  endtask

  // Full frame; data bytes right-aligned in wd/rd, first byte most significant.
  task automatic do_frame(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int errs, output logic post_out);
    logic [7:0] b;
    int e0;
    e0 = err_total;
    oe_bad = 0;
    rd = '0;
    cs_n = 1'b0;
    tick(HALF);
    spi_byte(cmd, 1'b0, b);
    if (cmd == 8'h02 || cmd == 8'h03) begin
      spi_byte(addr[23:16], 1'b0, b);
      spi_byte(addr[15:8], 1'b0, b);
      spi_byte(addr[7:0], 1'b0, b);
      for (int k = 0; k < n; k++) begin
        if (cmd == 8'h02) begin
          spi_byte(wd[8*(n-1-k) +: 8], 1'b0, b);
          ref_mem[16'(addr[15:0] + k)] = wd[8*(n-1-k) +: 8];
          ref_valid[16'(addr[15:0] + k)] = 1'b1;
        end else begin
          spi_byte(8'h00, 1'b1, b);
          rd = {rd[23:0], b};
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) spi_byte(8'hFF, 1'b0, b);
    end
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    post_out = miso | miso_oe | busy;
    errs = err_total - e0;
  endtask

  function automatic logic [31:0] model_read(input logic [23:0] addr, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = {r[23:0], ref_mem[16'(addr[15:0] + k)]};
    return r;
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          errs;
    logic        post;
    int          mism;

    vecs[0] = '{8'h02, 24'h000010, 4, 32'h11223344, 32'h0, 0};
    vecs[1] = '{8'h03, 24'h000010, 4, 32'h0, 32'h11223344, 0};
    vecs[2] = '{8'h03, 24'h000020, 4, 32'h0, 32'hDEADBEEF, 0};
    vecs[3] = '{8'h03, 24'h05FFFE, 4, 32'h0, 32'hA1B2C3D4, 0};
    vecs[4] = '{8'hAB, 24'h000000, 0, 32'h0, 32'h0, 1};
    vecs[5] = '{8'h02, 24'h000040, 2, 32'h00006677, 32'h0, 0};
    vecs[6] = '{8'h03, 24'h000040, 2, 32'h0, 32'h00006677, 0};
    vecs[7] = '{8'h02, 24'h12FFFF, 2, 32'h000099AA, 32'h0, 0};
    vecs[8] = '{8'h03, 24'h00FFFF, 3, 32'h0, 32'h0099AAD4, 0};

    for (int i = 0; i < 65536; i++) ref_valid[i] = 1'b0;

    tick(6);
    check("reset_outputs", {28'h0, miso, miso_oe, busy, cmd_err}, 32'h0);
    reset = 1'b0;
    tick(4);
    check("idle_outputs", {28'h0, miso, miso_oe, busy, cmd_err}, 32'h0);

    for (int a = 16'h10; a <= 16'h13; a++) bd_write(16'(a), 8'h00);
    bd_write(16'h0020, 8'hDE); bd_write(16'h0021, 8'hAD);
    bd_write(16'h0022, 8'hBE); bd_write(16'h0023, 8'hEF);
    bd_write(16'hFFFE, 8'hA1); bd_write(16'hFFFF, 8'hB2);
    bd_write(16'h0000, 8'hC3); bd_write(16'h0001, 8'hD4);
    bd_write(16'h0030, 8'h5A);
    for (int a = 16'h100; a < 16'h210; a++) bd_write(16'(a), 8'($urandom));

    for (int i = 0; i < 9; i++) begin
      do_frame(vecs[i].cmd, vecs[i].addr, vecs[i].n, vecs[i].wd, rd, errs, post);
      check($sformatf("vec%0d_cmd_err", i), errs, vecs[i].exp_err);
      check($sformatf("vec%0d_oe", i), oe_bad, 0);
      check($sformatf("vec%0d_post", i), {31'h0, post}, 32'h0);
      if (vecs[i].cmd == 8'h03) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    for (int a = 0; a < 4; a++) begin
      bd_read(16'(16'h10 + a), b);
      check($sformatf("bd_write_%0d", a), {24'h0, b}, {24'h0, vecs[0].wd[8*(3-a) +: 8]});
    end

    // Abort mid-byte: partial byte must not be written.
    cs_n = 1'b0;
    tick(HALF);
    spi_byte(8'h02, 1'b0, b); spi_byte(8'h00, 1'b0, b);
    spi_byte(8'h00, 1'b0, b); spi_byte(8'h30, 1'b0, b);
    for (int k = 0; k < 5; k++) spi_bit(1'b1, 1'b0, b[0]);
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    bd_read(16'h0030, b);
    check("abort_bd", {24'h0, b}, 32'h5A);
    do_frame(8'h03, 24'h000030, 1, 32'h0, rd, errs, post);
    check("abort_spi_read", rd, 32'h5A);

    // Reset during read data with CS_N held low.
    oe_bad = 0;
    cs_n = 1'b0;
    tick(HALF);
    spi_byte(8'h03, 1'b0, b); spi_byte(8'h00, 1'b0, b);
    spi_byte(8'h00, 1'b0, b); spi_byte(8'h20, 1'b0, b);
    spi_byte(8'h00, 1'b1, b);
    check("rst_first_byte", {24'h0, b}, 32'hDE);
    spi_bit(1'b0, 1'b1, b[0]);
    spi_bit(1'b0, 1'b1, b[0]);
    reset = 1'b1;
    tick(3);
    check("rst_during", {28'h0, miso, miso_oe, busy, cmd_err}, 32'h0);
    reset = 1'b0;
    tick(4);
    check("rst_after", {29'h0, miso, miso_oe, cmd_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    spi_byte(8'h03, 1'b0, b); spi_byte(8'h00, 1'b0, b);
    spi_byte(8'h00, 1'b0, b); spi_byte(8'h20, 1'b0, b);
    spi_byte(8'h00, 1'b0, b); spi_byte(8'h00, 1'b0, b);
    check("rst_no_decode_oe", oe_bad, 0);
    check("rst_no_decode_miso", {31'h0, miso}, 32'h0);
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    do_frame(8'h03, 24'h000020, 2, 32'h0, rd, errs, post);
    check("rst_next_frame", rd, 32'h0000DEAD);

    // Random frames with aliased upper address bits.
    for (int i = 0; i < 24; i++) begin
      int          r, n;
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [31:0] wd, exp_rd;
      r = $urandom_range(0, 9);
      cmd = (r == 0) ? (8'($urandom) | 8'h80) : (r < 5 ? 8'h02 : 8'h03);
      addr = {8'($urandom), 8'h01, 8'($urandom)};
      n = $urandom_range(1, 4);
      wd = $urandom;
      if (n < 4) wd = wd & ((32'h1 << (8 * n)) - 1);
      exp_rd = model_read(addr, n);
      do_frame(cmd, addr, n, wd, rd, errs, post);
      check($sformatf("rnd%0d_err", i), errs, (r == 0) ? 1 : 0);
      check($sformatf("rnd%0d_oe", i), oe_bad, 0);
      if (cmd == 8'h03) check($sformatf("rnd%0d_rd", i), rd, exp_rd);
      bd_write(16'(16'h100 + $urandom_range(0, 255)), 8'($urandom));
    end

    mism = 0;
    for (int a = 0; a < 65536; a++) begin
      if (ref_valid[a]) begin
        bd_read(16'(a), b);
        if (b !== ref_mem[a]) mism++;
      end
    end
    check("mem_sweep_mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
